// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_stream serialiser.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding buffer in front of the shifter: captures on valid&&ready,
// hands the word over when the shifter asserts take.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             take,
    output logic [WIDTH-1:0] word,
    output logic             full
);

    // data_ready is its own flop (always !full) so upstream sees no
    // combinational path from data_valid.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the data register is reset along with the flags so a discarded
    // word never leaks into the next transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full       <= 1'b0;
            data_ready <= 1'b1;
            word       <= '0;
        end else if (take) begin
            full       <= 1'b0;
            data_ready <= 1'b1;
        end else if (data_valid && data_ready) begin
            word       <= data;
            full       <= 1'b1;
            data_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-word holding buffer, selectable
// bit order and an external shift strobe; all outputs registered.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             shift_en,
    output logic             q,
    output logic             busy,
    output logic             word_done
);

    localparam int            CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    count, count_nx;
    logic             done_nx;
    logic             take;
    logic [WIDTH-1:0] hold_word;
    logic             hold_full;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .take       (take),
        .word       (hold_word),
        .full       (hold_full)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        count_nx = count;
        done_nx  = 1'b0;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    take     = 1'b1;
                    sreg_nx  = hold_word;
                    count_nx = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (count == LAST) begin
                        done_nx = 1'b1;
                        if (hold_full) begin
                            take     = 1'b1;
                            sreg_nx  = hold_word;
                            count_nx = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        sreg_nx  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                             : {1'b0, sreg[WIDTH-1:1]};
                        count_nx = count + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // q and busy are computed from next-state values so they are true flops
    // yet change on the same edge as the shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            count     <= '0;
            q         <= IDLE_LEVEL;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nx;
            sreg      <= sreg_nx;
            count     <= count_nx;
            q         <= (state_nx == SHIFT) ? head(sreg_nx) : IDLE_LEVEL;
            busy      <= (state_nx == SHIFT);
            word_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench: two DUTs (MSB-first and LSB-first) share one stimulus;
// a bit-level reference queue predicts q, busy and word_done for both.
module tb_piso_stream;

    localparam int W    = 8;
    localparam bit IDLE = 1'b1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data;
    logic         data_valid;
    logic         shift_en;
    logic         ready_m, q_m, busy_m, done_m;
    logic         ready_l, q_l, busy_l, done_l;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) u_msb (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .data_ready(ready_m), .shift_en(shift_en), .q(q_m), .busy(busy_m),
        .word_done(done_m)
    );

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) u_lsb (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .data_ready(ready_l), .shift_en(shift_en), .q(q_l), .busy(busy_l),
        .word_done(done_l)
    );

    // One entry per serial bit: expected bit for each lane, end-of-word flag,
    // and the edge count just before the word's accept edge.
    typedef struct {
        logic bm;
        logic bl;
        logic last;
        int   acc;
    } bit_t;

    bit_t sb[$];
    int   errors      = 0;
    int   checks      = 0;
    int   cyc         = 0;
    int   bits_popped = 0;
    int   shift_mode  = 0;
    int   phase       = 0;
    logic exp_done    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            bit_t e;
            e.bm   = w[W-1-i];
            e.bl   = w[i];
            e.last = (i == W - 1);
            e.acc  = cyc;
            sb.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe generator: 0 off, 1 every cycle, 4 every fourth cycle, else random.
    always @(negedge clk) begin
        phase = phase + 1;
        case (shift_mode)
            0:       shift_en = 1'b0;
            1:       shift_en = 1'b1;
            4:       shift_en = (phase % 4 == 0);
            default: shift_en = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a word is on the wire from the second edge after its accept
    // edge until its last bit is strobed out.
    always @(negedge clk) begin
        logic exp_busy;
        #1;
        if (reset) begin
            exp_done = 1'b0;
        end else begin
            check("word_done_msb", done_m, exp_done);
            check("word_done_lsb", done_l, exp_done);
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
            check("busy_msb", busy_m, exp_busy);
            check("busy_lsb", busy_l, exp_busy);
            if (exp_busy) begin
                check("q_msb", q_m, sb[0].bm);
                check("q_lsb", q_l, sb[0].bl);
                exp_done = shift_en ? sb[0].last : 1'b0;
                if (shift_en) begin
                    void'(sb.pop_front());
                    bits_popped++;
                end
            end else begin
                check("q_idle_msb", q_m, IDLE);
                check("q_idle_lsb", q_l, IDLE);
                exp_done = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        data       = w;
        data_valid = 1'b1;
        while (!ready_m && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_timeout", 32'(n >= 300), 0);
        if (n < 300) begin
            push_word(w);
            check("ready_lsb_at_accept", ready_l, 1);
            @(negedge clk);
            data_valid = 1'b0;
            check("ready_low_after_accept_msb", ready_m, 0);
            check("ready_low_after_accept_lsb", ready_l, 0);
        end else begin
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
        repeat (2) @(negedge clk);
        #2;
        check("idle_busy", busy_m | busy_l, 0);
        check("idle_ready", ready_m & ready_l, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_q_msb", q_m, IDLE);
        check("rst_q_lsb", q_l, IDLE);
        check("rst_busy", busy_m | busy_l, 0);
        check("rst_done", done_m | done_l, 0);
        check("rst_ready", ready_m & ready_l, 1);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        data       = '0;
        data_valid = 1'b0;
        shift_en   = 1'b0;
        #2;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check_reset_outputs();

        // Single words, strobe every cycle: 0x99 (MSB lane) and 0x61 (LSB lane).
        shift_mode = 1;
        send_word(8'b10011001);
        wait_drain();
        send_word(8'b01100001);
        wait_drain();

        // Back-to-back: second word buffered while the first shifts.
        send_word(8'h99);
        send_word(8'h61);
        wait_drain();

        // Slow strobe: one shift every four cycles.
        shift_mode = 4;
        send_word(8'hA5);
        wait_drain();

        // Reset mid-word with a word buffered.
        shift_mode = 0;
        send_word(8'hF0);
        send_word(8'h0F);
        n = bits_popped;
        shift_mode = 1;
        while (bits_popped < n + 3 && bits_popped < n + 100) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_word(8'h3C);
        wait_drain();

        // valid held while the buffer is full: 0x55 must be taken exactly once.
        shift_mode = 1;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h55);
        wait_drain();

        // Randomised words, gaps and strobe patterns.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       shift_mode = 1;
                1:       shift_mode = 4;
                default: shift_mode = 9;
            endcase
            repeat ($urandom_range(0, 6)) @(negedge clk);
            send_word(W'($urandom));
        end
        shift_mode = 1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
